// File: rtl/cpu_defs.sv
// Shared definitions for the hardwired control unit: instruction fields,
// opcodes, FSM state encoding and instruction-class decode.
package cpu_defs;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;
  localparam int SEL_W = 4;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11001;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU3,
    CLS_MULDIV,
    CLS_NEGNOT,
    CLS_HALT
  } instr_cls_e;

  // Unrecognised opcodes fall into CLS_NOP so they retire after fetch.
  function automatic instr_cls_e op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR: return CLS_ALU3;
      OP_MUL, OP_DIV:                return CLS_MULDIV;
      OP_NEG, OP_NOT:                return CLS_NEGNOT;
      OP_HALT:                       return CLS_HALT;
      default:                       return CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register-field to one-hot select; all zeros when disabled.
module reg_select_decoder
  import cpu_defs::*;
#(
  parameter int REGISTERS = 16
) (
  input  logic [SEL_W-1:0]     i_sel,
  input  logic                 i_en,
  output logic [REGISTERS-1:0] o_onehot
);

  for (genvar g = 0; g < REGISTERS; g++) begin : g_sel
    assign o_onehot[g] = i_en && (i_sel == SEL_W'(g));
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit: fetch (T0-T2) plus execute (T3-T6) for the register
// ALU, mul/div, neg/not, nop and halt instructions, one step per clock.
module control_sequencer
  import cpu_defs::*;
#(
  parameter int BITS      = 32,
  parameter int REGISTERS = 16
) (
  input  logic                 Clock,
  input  logic                 reset,
  input  logic [BITS-1:0]      IR,
  input  logic                 Stop,
  output logic                 Run,
  output logic [REGISTERS-1:0] GPRin,
  output logic [REGISTERS-1:0] GPRout,
  output logic                 PCin,
  output logic                 IRin,
  output logic                 RYin,
  output logic                 RZin,
  output logic                 MARin,
  output logic                 HIin,
  output logic                 LOin,
  output logic                 MDRin,
  output logic                 PCout,
  output logic                 MDRout,
  output logic                 LOout,
  output logic                 HIout,
  output logic                 Zhighout,
  output logic                 Zlowout,
  output logic                 Read,
  output logic                 IncPC,
  output logic                 ADD,
  output logic                 SUB,
  output logic                 MUL,
  output logic                 DIV,
  output logic                 SHR,
  output logic                 SHL,
  output logic                 ROR,
  output logic                 ROL,
  output logic                 AND,
  output logic                 OR,
  output logic                 NEGATE,
  output logic                 NOT
);

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic             w_last;
  logic [4:0]       w_op;
  logic [SEL_W-1:0] w_ra, w_rb, w_rc;
  instr_cls_e       w_cls;
  logic             w_alu3, w_muldiv, w_negnot;
  logic [SEL_W-1:0] w_in_sel, w_out_sel;
  logic             w_in_en, w_out_en, w_strobe;
  logic             w_unused_ir;

  assign w_op        = IR[OP_HI:OP_LO];
  assign w_ra        = IR[RA_HI:RA_LO];
  assign w_rb        = IR[RB_HI:RB_LO];
  assign w_rc        = IR[RC_HI:RC_LO];
  assign w_unused_ir = ^IR[RC_LO-1:0];
  assign w_cls       = op_class(w_op);
  assign w_alu3      = (w_cls == CLS_ALU3);
  assign w_muldiv    = (w_cls == CLS_MULDIV);
  assign w_negnot    = (w_cls == CLS_NEGNOT);

  // IR is consulted in T2 only to pick the branch out of fetch; the fetch
  // outputs themselves never depend on it.
  always_comb begin
    w_next = r_state;
    w_last = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_T0;
      S_T0:   w_next = S_T1;
      S_T1:   w_next = S_T2;
      S_T2: begin
        if (w_cls == CLS_HALT)     w_next = S_HALT;
        else if (w_cls == CLS_NOP) w_last = 1'b1;
        else                       w_next = S_T3;
      end
      S_T3: begin
        if (w_alu3 || w_muldiv || w_negnot) w_next = S_T4;
        else                                w_last = 1'b1;
      end
      S_T4: begin
        if (w_alu3 || w_muldiv) w_next = S_T5;
        else                    w_last = 1'b1;
      end
      S_T5: begin
        if (w_muldiv) w_next = S_T6;
        else          w_last = 1'b1;
      end
      S_T6:   w_last = 1'b1;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
    if (w_last) w_next = Stop ? S_HALT : S_T0;
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    PCin      = 1'b0;
    IRin      = 1'b0;
    RYin      = 1'b0;
    RZin      = 1'b0;
    MARin     = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    MDRin     = 1'b0;
    PCout     = 1'b0;
    MDRout    = 1'b0;
    Zhighout  = 1'b0;
    Zlowout   = 1'b0;
    Read      = 1'b0;
    IncPC     = 1'b0;
    w_in_sel  = w_ra;
    w_in_en   = 1'b0;
    w_out_sel = w_rb;
    w_out_en  = 1'b0;
    w_strobe  = 1'b0;
    case (r_state)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        w_out_en  = w_alu3 || w_muldiv || w_negnot;
        w_out_sel = w_muldiv ? w_ra : w_rb;
        RYin      = w_alu3 || w_muldiv;
        RZin      = w_negnot;
        w_strobe  = w_negnot;
      end
      S_T4: begin
        w_out_en  = w_alu3 || w_muldiv;
        w_out_sel = w_alu3 ? w_rc : w_rb;
        RZin      = w_alu3 || w_muldiv;
        w_strobe  = w_alu3 || w_muldiv;
        Zlowout   = w_negnot;
        w_in_en   = w_negnot;
      end
      S_T5: begin
        Zlowout = w_alu3 || w_muldiv;
        w_in_en = w_alu3;
        LOin    = w_muldiv;
      end
      S_T6: begin
        Zhighout = w_muldiv;
        HIin     = w_muldiv;
      end
      default: ;
    endcase
  end

  assign Run    = (r_state != S_IDLE) && (r_state != S_HALT);
  assign LOout  = 1'b0;
  assign HIout  = 1'b0;

  // w_strobe already qualifies the step, so at most one strobe is high.
  assign ADD    = w_strobe && (w_op == OP_ADD);
  assign SUB    = w_strobe && (w_op == OP_SUB);
  assign MUL    = w_strobe && (w_op == OP_MUL);
  assign DIV    = w_strobe && (w_op == OP_DIV);
  assign SHR    = w_strobe && (w_op == OP_SHR);
  assign SHL    = w_strobe && (w_op == OP_SHL);
  assign ROR    = w_strobe && (w_op == OP_ROR);
  assign ROL    = w_strobe && (w_op == OP_ROL);
  assign AND    = w_strobe && (w_op == OP_AND);
  assign OR     = w_strobe && (w_op == OP_OR);
  assign NEGATE = w_strobe && (w_op == OP_NEG);
  assign NOT    = w_strobe && (w_op == OP_NOT);

  reg_select_decoder #(.REGISTERS(REGISTERS)) u_gpr_in (
    .i_sel    (w_in_sel),
    .i_en     (w_in_en),
    .o_onehot (GPRin)
  );

  reg_select_decoder #(.REGISTERS(REGISTERS)) u_gpr_out (
    .i_sel    (w_out_sel),
    .i_en     (w_out_en),
    .o_onehot (GPRout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-step control words against a table model,
// plus a small behavioural datapath to check end-to-end register results.
module tb_control_sequencer;
  localparam int BITS = 32;
  localparam int REGISTERS = 16;

  logic Clock = 1'b0;
  logic reset = 1'b0;
  logic Stop = 1'b0;
  logic [BITS-1:0] IR = '0;
  logic Run;
  logic [REGISTERS-1:0] GPRin, GPRout;
  logic PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin;
  logic PCout, MDRout, LOout, HIout, Zhighout, Zlowout, Read, IncPC;
  logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT;

  control_sequencer #(.BITS(BITS), .REGISTERS(REGISTERS)) dut (
    .Clock(Clock), .reset(reset), .IR(IR), .Stop(Stop), .Run(Run),
    .GPRin(GPRin), .GPRout(GPRout), .PCin(PCin), .IRin(IRin), .RYin(RYin),
    .RZin(RZin), .MARin(MARin), .HIin(HIin), .LOin(LOin), .MDRin(MDRin),
    .PCout(PCout), .MDRout(MDRout), .LOout(LOout), .HIout(HIout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .Read(Read), .IncPC(IncPC),
    .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL),
    .ROR(ROR), .ROL(ROL), .AND(AND), .OR(OR), .NEGATE(NEGATE), .NOT(NOT)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic        run;
    logic [15:0] gin;
    logic [15:0] gout;
    logic pcin, irin, ryin, rzin, marin, hiin, loin, mdrin;
    logic pcout, mdrout, loout, hiout, zhout, zlout, rd, incpc;
    logic [11:0] alu; // ADD SUB MUL DIV SHR SHL ROR ROL AND OR NEGATE NOT
  } ctl_t;

  ctl_t act;
  assign act = {Run, GPRin, GPRout, PCin, IRin, RYin, RZin, MARin, HIin, LOin,
                MDRin, PCout, MDRout, LOout, HIout, Zhighout, Zlowout, Read,
                IncPC, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE,
                NOT};

  int checks = 0;
  int failures = 0;
  ctl_t obs_q[$];

  // Behavioural datapath driven by the DUT's controls.
  logic [31:0] R [16];
  logic [31:0] ld_vals [16];
  logic        ld_req = 1'b0;
  logic [31:0] Y, PC = 32'h100, MDR, HI, LO;
  logic [63:0] Z;
  logic [31:0] bus;

  always_comb begin
    bus = '0;
    for (int i = 0; i < 16; i++) if (GPRout[i]) bus = bus | R[i];
    if (PCout)    bus = bus | PC;
    if (MDRout)   bus = bus | MDR;
    if (Zlowout)  bus = bus | Z[31:0];
    if (Zhighout) bus = bus | Z[63:32];
    if (LOout)    bus = bus | LO;
    if (HIout)    bus = bus | HI;
  end

  always @(posedge Clock) begin
    if (ld_req) R <= ld_vals;
    if (RYin) Y <= bus;
    if (RZin) begin
      if (IncPC)       Z <= {32'd0, bus + 32'd1};
      else if (ADD)    Z <= {32'd0, Y + bus};
      else if (SUB)    Z <= {32'd0, Y - bus};
      else if (AND)    Z <= {32'd0, Y & bus};
      else if (OR)     Z <= {32'd0, Y | bus};
      else if (SHR)    Z <= {32'd0, Y >> bus[4:0]};
      else if (SHL)    Z <= {32'd0, Y << bus[4:0]};
      else if (ROR)    Z <= {32'd0, (Y >> bus[4:0]) | (Y << (32 - 32'(bus[4:0])))};
      else if (ROL)    Z <= {32'd0, (Y << bus[4:0]) | (Y >> (32 - 32'(bus[4:0])))};
      else if (MUL)    Z <= 64'(Y) * 64'(bus);
      else if (DIV)    Z <= (bus == 0) ? 64'd0 : {Y % bus, Y / bus};
      else if (NEGATE) Z <= {32'd0, -bus};
      else if (NOT)    Z <= {32'd0, ~bus};
    end
    for (int i = 0; i < 16; i++) if (GPRin[i]) R[i] <= bus;
    if (LOin)  LO <= bus;
    if (HIin)  HI <= bus;
    if (PCin)  PC <= bus;
    if (MDRin) MDR <= Read ? 32'h0 : bus;
  end

  // 0 nop/unknown, 1 three-register ALU, 2 mul/div, 3 neg/not, 4 halt
  function automatic int instr_kind(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010: return 1;
      5'b01110, 5'b01111:                     return 2;
      5'b10000, 5'b10001:                     return 3;
      5'b11001:                               return 4;
      default:                                return 0;
    endcase
  endfunction

  function automatic int n_steps(input logic [4:0] op);
    case (instr_kind(op))
      1: return 6;
      2: return 7;
      3: return 5;
      default: return 3;
    endcase
  endfunction

  function automatic logic [11:0] strobe_of(input logic [4:0] op);
    case (op)
      5'b00011: return 12'b1000_0000_0000;
      5'b00100: return 12'b0100_0000_0000;
      5'b01110: return 12'b0010_0000_0000;
      5'b01111: return 12'b0001_0000_0000;
      5'b00101: return 12'b0000_1000_0000;
      5'b00110: return 12'b0000_0100_0000;
      5'b00111: return 12'b0000_0010_0000;
      5'b01000: return 12'b0000_0001_0000;
      5'b01001: return 12'b0000_0000_1000;
      5'b01010: return 12'b0000_0000_0100;
      5'b10000: return 12'b0000_0000_0010;
      5'b10001: return 12'b0000_0000_0001;
      default:  return 12'b0;
    endcase
  endfunction

  // Expected control word for step t (t=0 is T0) of instruction ir.
  function automatic ctl_t exp_step(input logic [31:0] ir, input int t);
    ctl_t e;
    int k;
    logic [3:0] ra, rb, rc;
    e = '0;
    k = instr_kind(ir[31:27]);
    ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    e.run = 1'b1;
    if (t == 0) begin
      e.pcout = 1; e.marin = 1; e.incpc = 1; e.rzin = 1;
    end else if (t == 1) begin
      e.zlout = 1; e.pcin = 1; e.rd = 1; e.mdrin = 1;
    end else if (t == 2) begin
      e.mdrout = 1; e.irin = 1;
    end else if (k == 1) begin
      if (t == 3) begin e.gout = 16'd1 << rb; e.ryin = 1; end
      if (t == 4) begin e.gout = 16'd1 << rc; e.alu = strobe_of(ir[31:27]); e.rzin = 1; end
      if (t == 5) begin e.zlout = 1; e.gin = 16'd1 << ra; end
    end else if (k == 2) begin
      if (t == 3) begin e.gout = 16'd1 << ra; e.ryin = 1; end
      if (t == 4) begin e.gout = 16'd1 << rb; e.alu = strobe_of(ir[31:27]); e.rzin = 1; end
      if (t == 5) begin e.zlout = 1; e.loin = 1; end
      if (t == 6) begin e.zhout = 1; e.hiin = 1; end
    end else if (k == 3) begin
      if (t == 3) begin e.gout = 16'd1 << rb; e.alu = strobe_of(ir[31:27]); e.rzin = 1; end
      if (t == 4) begin e.zlout = 1; e.gin = 16'd1 << ra; end
    end
    return e;
  endfunction

  // Drives one instruction from its T0, recording the control word per step.
  task automatic run_instr(input logic [31:0] ir, input int stop_step, input bit do_load);
    IR = ir;
    obs_q.delete();
    for (int t = 0; t < n_steps(ir[31:27]); t++) begin
      if (t == 0 && do_load) ld_req = 1'b1;
      if (t == 1) ld_req = 1'b0;
      if (t == stop_step) Stop = 1'b1;
      obs_q.push_back(act);
      @(negedge Clock);
    end
  endtask

  task automatic rand_regs();
    for (int i = 0; i < 16; i++) ld_vals[i] = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b0; Stop = 1'b0; IR = 32'h4A920000;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      checks++;
      if (act !== '0) begin failures++; $display("FAIL reset_hold cyc%0d: got %h want 0", i, act); end
    end
    reset = 1'b1;
    @(negedge Clock);
    checks++;
    if (act !== exp_step(IR, 0)) begin failures++; $display("FAIL reset_release_t0: got %h want %h", act, exp_step(IR, 0)); end
  endtask

  task automatic test_and();
    rand_regs(); ld_vals[2] = 32'h22; ld_vals[4] = 32'h24;
    run_instr(32'h4A920000, -1, 1'b1);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_step(32'h4A920000, i)) begin
        failures++; $display("FAIL and_step%0d: got %h want %h", i, obs_q[i], exp_step(32'h4A920000, i));
      end
    end
    checks++;
    if (R[5] !== 32'h20) begin failures++; $display("FAIL and_result: got %h want 00000020", R[5]); end
  endtask

  task automatic test_mul();
    rand_regs(); ld_vals[3] = 32'd6; ld_vals[1] = 32'h10000000;
    run_instr(32'h71880000, -1, 1'b1);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_step(32'h71880000, i)) begin
        failures++; $display("FAIL mul_step%0d: got %h want %h", i, obs_q[i], exp_step(32'h71880000, i));
      end
    end
    checks++;
    if (LO !== 32'h60000000 || HI !== 32'h0) begin
      failures++; $display("FAIL mul_result: got HI=%h LO=%h want HI=0 LO=60000000", HI, LO);
    end
  endtask

  task automatic test_neg();
    rand_regs(); ld_vals[6] = 32'd1;
    run_instr(32'h83B00000, -1, 1'b1);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_step(32'h83B00000, i)) begin
        failures++; $display("FAIL neg_step%0d: got %h want %h", i, obs_q[i], exp_step(32'h83B00000, i));
      end
    end
    checks++;
    if (R[7] !== 32'hFFFFFFFF) begin failures++; $display("FAIL neg_result: got %h want ffffffff", R[7]); end
  endtask

  task automatic test_unknown();
    run_instr(32'hF8000000, -1, 1'b0);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_step(32'hF8000000, i)) begin
        failures++; $display("FAIL unknown_step%0d: got %h want %h", i, obs_q[i], exp_step(32'hF8000000, i));
      end
    end
    checks++;
    if (act !== exp_step(IR, 0)) begin failures++; $display("FAIL unknown_next_t0: got %h want %h", act, exp_step(IR, 0)); end
  endtask

  task automatic test_random();
    logic [31:0] ir, a, b, x, want, got;
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    bit          chk;
    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'b11001) op = 5'b11000;
      ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
      if (n % 8 == 0) begin rb = ra; rc = ra; end
      ir = {op, ra, rb, rc, 15'($urandom)};
      rand_regs();
      if (op == 5'b01111 && ld_vals[rb] == 0) ld_vals[rb] = 32'd3;
      x = ld_vals[ra]; a = ld_vals[rb]; b = ld_vals[rc];
      run_instr(ir, -1, 1'b1);
      foreach (obs_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_step(ir, i)) begin
          failures++; $display("FAIL rand%0d_op%b_step%0d: got %h want %h", n, op, i, obs_q[i], exp_step(ir, i));
        end
      end
      chk = 1'b1; want = '0; got = '0;
      case (op)
        5'b00011: begin want = a + b;  got = R[ra]; end
        5'b00100: begin want = a - b;  got = R[ra]; end
        5'b01001: begin want = a & b;  got = R[ra]; end
        5'b01010: begin want = a | b;  got = R[ra]; end
        5'b10000: begin want = -a;     got = R[ra]; end
        5'b10001: begin want = ~a;     got = R[ra]; end
        5'b01110: begin want = x * a;  got = LO; end
        5'b01111: begin want = x / a;  got = LO; end
        default:  chk = 1'b0;
      endcase
      if (chk) begin
        checks++;
        if (got !== want) begin failures++; $display("FAIL rand%0d_op%b_result: got %h want %h", n, op, got, want); end
      end
    end
  endtask

  task automatic test_stop();
    logic [31:0] ir;
    ir = {5'b00011, 4'd9, 4'd10, 4'd11, 15'd0};
    rand_regs();
    run_instr(ir, 3, 1'b1);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_step(ir, i)) begin
        failures++; $display("FAIL stop_step%0d: got %h want %h", i, obs_q[i], exp_step(ir, i));
      end
    end
    checks++;
    if (R[9] !== ld_vals[10] + ld_vals[11]) begin
      failures++; $display("FAIL stop_result: got %h want %h", R[9], ld_vals[10] + ld_vals[11]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act !== '0) begin failures++; $display("FAIL stop_halted cyc%0d: got %h want 0", i, act); end
      @(negedge Clock);
    end
    Stop = 1'b0;
    reset = 1'b0; #1;
    checks++;
    if (act !== '0) begin failures++; $display("FAIL stop_reset_idle: got %h want 0", act); end
    @(negedge Clock); reset = 1'b1; @(negedge Clock);
    checks++;
    if (act !== exp_step(IR, 0)) begin failures++; $display("FAIL stop_restart_t0: got %h want %h", act, exp_step(IR, 0)); end
  endtask

  task automatic test_abandon();
    IR = 32'h4A920000;
    repeat (4) @(negedge Clock);
    checks++;
    if (act !== exp_step(IR, 4)) begin failures++; $display("FAIL abandon_in_t4: got %h want %h", act, exp_step(IR, 4)); end
    #2 reset = 1'b0; #1;
    checks++;
    if (act !== '0) begin failures++; $display("FAIL abandon_async_reset: got %h want 0", act); end
    @(negedge Clock); reset = 1'b1; @(negedge Clock);
    checks++;
    if (act !== exp_step(IR, 0)) begin failures++; $display("FAIL abandon_restart_t0: got %h want %h", act, exp_step(IR, 0)); end
  endtask

  task automatic test_halt();
    run_instr(32'hC8000000, -1, 1'b0);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_step(32'hC8000000, i)) begin
        failures++; $display("FAIL halt_step%0d: got %h want %h", i, obs_q[i], exp_step(32'hC8000000, i));
      end
    end
    IR = 32'h4A920000;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (act !== '0) begin failures++; $display("FAIL halt_hold cyc%0d: got %h want 0", i, act); end
      @(negedge Clock);
    end
    reset = 1'b0; #1;
    checks++;
    if (act !== '0) begin failures++; $display("FAIL halt_reset_idle: got %h want 0", act); end
    @(negedge Clock); reset = 1'b1; @(negedge Clock);
    checks++;
    if (act !== exp_step(IR, 0)) begin failures++; $display("FAIL halt_restart_t0: got %h want %h", act, exp_step(IR, 0)); end
  endtask

  initial begin
    test_reset();
    test_and();
    test_mul();
    test_neg();
    test_unknown();
    test_random();
    test_stop();
    test_abandon();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
